// File: rtl/cmutex_merge_n_d_sync_if.sv
// Handshake bundle for cmutex_merge_n_d_sync: N upstream drive/free channels with
// payloads plus the single downstream drive/free pair and status flags.
interface cmutex_merge_n_d_sync_if #(
    parameter int DATA_WIDTH = 128,
    parameter int N_IN       = 4
);
    localparam int IDX_W = $clog2(N_IN);

    logic [N_IN-1:0]            i_drive;
    logic [N_IN-1:0]            o_free;
    logic [N_IN*DATA_WIDTH-1:0] i_data;
    logic                       o_driveNext;
    logic                       i_freeNext;
    logic [DATA_WIDTH-1:0]      o_data;
    logic [IDX_W-1:0]           o_grant;
    logic                       o_busy;
    logic                       o_overrun;

    modport slave (
        input  i_drive, i_data, i_freeNext,
        output o_free, o_driveNext, o_data, o_grant, o_busy, o_overrun
    );

    modport master (
        output i_drive, i_data, i_freeNext,
        input  o_free, o_driveNext, o_data, o_grant, o_busy, o_overrun
    );
endinterface

// File: rtl/cmutex_merge_n_d_sync.sv
// Clocked N-input mutual-exclusion merge with registered payload and grant index.
// Define CMUTEXMERGE_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module cmutex_merge_n_d_sync #(
    parameter int DATA_WIDTH = 128,
    parameter int N_IN       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    cmutex_merge_n_d_sync_if.slave bus
);
    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                state_q, state_d;
    logic [N_IN-1:0]       pending_q, pending_d;
    logic [N_IN-1:0]       free_q, free_d;
    logic [N_IN-1:0]       clr;
    logic                  drive_next_q, drive_next_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      win;
    logic                  win_vld;
    logic [DATA_WIDTH-1:0] win_data;
`ifdef CMUTEXMERGE_RR_EN
    logic [IDX_W-1:0]      last_q, last_d;
    logic [IDX_W-1:0]      cand;
`endif

    // Winner is chosen from the registered pending set only, keeping inputs off the output path.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
`ifdef CMUTEXMERGE_RR_EN
        cand    = '0;
        for (int i = 0; i < N_IN; i++) begin
            cand = IDX_W'((int'(last_q) + 1 + i) % N_IN);
            if (!win_vld && pending_q[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
`else
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                win     = IDX_W'(i);
                win_vld = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (win == IDX_W'(k)) win_data = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        clr = '0;
        for (int k = 0; k < N_IN; k++) begin
            clr[k] = (state_q == ST_WAIT) && bus.i_freeNext && (grant_q == IDX_W'(k));
        end

        // A drive coinciding with its own completion re-arms the channel rather than overrunning.
        pending_d    = (pending_q & ~clr) | bus.i_drive;
        overrun_d    = overrun_q | (|(bus.i_drive & pending_q & ~clr));
        free_d       = clr;
        state_d      = state_q;
        drive_next_d = 1'b0;
        data_d       = data_q;
        grant_d      = grant_q;
`ifdef CMUTEXMERGE_RR_EN
        last_d       = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    data_d       = win_data;
                    grant_d      = win;
                    drive_next_d = 1'b1;
                    state_d      = ST_WAIT;
`ifdef CMUTEXMERGE_RR_EN
                    last_d       = win;
`endif
                end
            end
            ST_WAIT: begin
                if (bus.i_freeNext) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            free_q       <= '0;
            drive_next_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            data_q       <= '0;
            grant_q      <= '0;
`ifdef CMUTEXMERGE_RR_EN
            last_q       <= IDX_W'(N_IN - 1);
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            free_q       <= free_d;
            drive_next_q <= drive_next_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            data_q       <= data_d;
            grant_q      <= grant_d;
`ifdef CMUTEXMERGE_RR_EN
            last_q       <= last_d;
`endif
        end
    end

    assign bus.o_free      = free_q;
    assign bus.o_driveNext = drive_next_q;
    assign bus.o_data      = data_q;
    assign bus.o_grant     = grant_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_overrun   = overrun_q;
endmodule

// File: tb/tb_cmutex_merge_n_d_sync.sv
// Directed bench for cmutex_merge_n_d_sync with a channel-level reference model.
// Honours CMUTEXMERGE_RR_EN the same way as the design.
module tb_cmutex_merge_n_d_sync;
    localparam int DW = 128;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmutex_merge_n_d_sync_if #(.DATA_WIDTH(DW), .N_IN(N)) bus();

    cmutex_merge_n_d_sync #(.DATA_WIDTH(DW), .N_IN(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: set of waiting channels, channel currently owning downstream (-1 if none).
    logic [N-1:0]  m_pend  = '0;
    int            m_cur   = -1;
    int            m_last  = N - 1;
    int            m_clr;
    int            m_w;
    logic [N-1:0]  e_free  = '0;
    logic          e_drv   = 1'b0;
    logic          e_busy  = 1'b0;
    logic          e_ovr   = 1'b0;
    logic [DW-1:0] e_data  = '0;
    logic [1:0]    e_grant = '0;

    function automatic int pick(input logic [N-1:0] p, input int last);
`ifdef CMUTEXMERGE_RR_EN
        for (int i = 1; i <= N; i++) if (p[(last + i) % N]) return (last + i) % N;
`else
        for (int i = 0; i < N; i++) if (p[i]) return i + 0 * last;
`endif
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_pend = '0; m_cur = -1; m_last = N - 1;
                e_free = '0; e_drv = 1'b0; e_busy = 1'b0; e_ovr = 1'b0;
                e_data = '0; e_grant = '0;
            end else begin
                m_clr  = (m_cur >= 0 && bus.i_freeNext) ? m_cur : -1;
                e_free = '0;
                if (m_clr >= 0) e_free[m_clr] = 1'b1;
                for (int k = 0; k < N; k++)
                    if (bus.i_drive[k] && m_pend[k] && k != m_clr) e_ovr = 1'b1;
                e_drv = 1'b0;
                if (m_cur < 0) begin
                    m_w = pick(m_pend, m_last);
                    if (m_w >= 0) begin
                        e_drv   = 1'b1;
                        e_grant = 2'(m_w);
                        e_data  = bus.i_data[m_w*DW +: DW];
                        m_cur   = m_w;
                        m_last  = m_w;
                    end
                end else if (m_clr >= 0) begin
                    m_cur = -1;
                end
                for (int k = 0; k < N; k++)
                    m_pend[k] = (m_pend[k] && k != m_clr) || bus.i_drive[k];
                e_busy = (m_cur >= 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            n_vec++;
            if (bus.o_free !== e_free || bus.o_driveNext !== e_drv || bus.o_busy !== e_busy ||
                bus.o_overrun !== e_ovr || bus.o_grant !== e_grant || bus.o_data !== e_data) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t got/exp free=%b/%b drv=%b/%b busy=%b/%b ovr=%b/%b grant=%0d/%0d data=%0h/%0h",
                         $time, bus.o_free, e_free, bus.o_driveNext, e_drv, bus.o_busy, e_busy,
                         bus.o_overrun, e_ovr, bus.o_grant, e_grant, bus.o_data, e_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; returns 2 time units after the next rising edge.
    task automatic cyc(input logic [N-1:0] drv, input logic fn);
        bus.i_drive    = drv;
        bus.i_freeNext = fn;
        @(posedge clk);
        #2;
        bus.i_drive    = '0;
        bus.i_freeNext = 1'b0;
    endtask

    // Wait for the next downstream request, complete it at once, report its channel.
    task automatic serve(input logic [N-1:0] redrv, output int g);
        g = -1;
        for (int t = 0; t < 12; t++) begin
            if (bus.o_driveNext === 1'b1) begin
                g = int'(bus.o_grant);
                cyc(redrv, 1'b1);
                return;
            end
            cyc('0, 1'b0);
        end
        n_vec++;
        n_bad++;
        $display("FAIL serve_timeout: got no o_driveNext in 12 cycles, expected a grant");
    endtask

    int g0, g1, g2, g3, cnt;

    initial begin
        bus.i_drive    = '0;
        bus.i_freeNext = 1'b0;
        bus.i_data     = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_free",    128'(bus.o_free),      128'h0);
        chk("rst_drv",     128'(bus.o_driveNext), 128'h0);
        chk("rst_data",    bus.o_data,            128'h0);
        chk("rst_grant",   128'(bus.o_grant),     128'h0);
        chk("rst_busy",    128'(bus.o_busy),      128'h0);
        chk("rst_overrun", 128'(bus.o_overrun),   128'h0);
        rst = 1'b1;
        cyc('0, 1'b0);

        // Simultaneous requests from a fresh reset: served 0, 1, 3.
        bus.i_data[0*DW +: DW] = 128'h11;
        bus.i_data[1*DW +: DW] = 128'h22;
        bus.i_data[3*DW +: DW] = 128'h33;
        cyc(4'b1011, 1'b0);
        serve('0, g0); serve('0, g1); serve('0, g2);
        chk("simul_g0", 128'(g0), 128'd0);
        chk("simul_g1", 128'(g1), 128'd1);
        chk("simul_g2", 128'(g2), 128'd3);
        chk("simul_data", bus.o_data, 128'h33);

        // Single request timing on channel 2.
        cyc('0, 1'b0);
        bus.i_data[2*DW +: DW] = 128'hA5;
        cyc(4'b0100, 1'b0);
        chk("single_c1_drv", 128'(bus.o_driveNext), 128'h0);
        cyc('0, 1'b0);
        chk("single_c2_drv",   128'(bus.o_driveNext), 128'h1);
        chk("single_c2_data",  bus.o_data,            128'hA5);
        chk("single_c2_grant", 128'(bus.o_grant),     128'd2);
        chk("single_c2_busy",  128'(bus.o_busy),      128'h1);
        cyc('0, 1'b1);
        chk("single_c3_free", 128'(bus.o_free),      128'h4);
        chk("single_c3_busy", 128'(bus.o_busy),      128'h0);
        chk("single_c3_drv",  128'(bus.o_driveNext), 128'h0);
        cyc('0, 1'b0);
        chk("single_c4_free", 128'(bus.o_free), 128'h0);

`ifdef CMUTEXMERGE_RR_EN
        // Round-robin wrap: last=3 then pending {0,3} -> 0 then 3; then 0; then last=0 -> 3 before 0.
        cyc(4'b1000, 1'b0); serve('0, g0);
        chk("rr_setup3", 128'(g0), 128'd3);
        cyc(4'b1001, 1'b0); serve('0, g0); serve('0, g1);
        chk("rr_wrap_a", 128'(g0), 128'd0);
        chk("rr_wrap_b", 128'(g1), 128'd3);
        cyc(4'b0001, 1'b0); serve('0, g2);
        chk("rr_redrive0", 128'(g2), 128'd0);
        cyc(4'b1001, 1'b0); serve('0, g0); serve('0, g1);
        chk("rr_after0_a", 128'(g0), 128'd3);
        chk("rr_after0_b", 128'(g1), 128'd0);
`else
        // Fixed priority: channel 0 re-driven on its own completion starves 1 and 3.
        cyc(4'b1011, 1'b0);
        for (int r = 0; r < 4; r++) begin
            serve(4'b0001, g0);
            chk("starve_g0", 128'(g0), 128'd0);
        end
        serve('0, g0); serve('0, g1); serve('0, g2);
        chk("drain_a", 128'(g0), 128'd0);
        chk("drain_b", 128'(g1), 128'd1);
        chk("drain_c", 128'(g2), 128'd3);
`endif

        // Persistence after completion and ignored free in IDLE.
        cyc('0, 1'b0);
        bus.i_data[1*DW +: DW] = 128'h77;
        cyc(4'b0010, 1'b0); serve('0, g3);
        chk("persist_grant", 128'(g3), 128'd1);
        bus.i_data[1*DW +: DW] = 128'h99;
        repeat (3) cyc('0, 1'b0);
        chk("persist_data",  bus.o_data,        128'h77);
        chk("persist_grant2", 128'(bus.o_grant), 128'd1);
        cyc('0, 1'b1);
        chk("spurious_free", 128'(bus.o_free), 128'h0);
        chk("spurious_busy", 128'(bus.o_busy), 128'h0);
        cyc('0, 1'b0);
        chk("spurious_free2", 128'(bus.o_free), 128'h0);

        // Overrun: second drive on channel 1 while it is pending.
        chk("ovr_before", 128'(bus.o_overrun), 128'h0);
        cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b0);
        chk("ovr_set", 128'(bus.o_overrun), 128'h1);
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            if (bus.o_driveNext === 1'b1 && bus.o_grant === 2'd1) cnt++;
            cyc('0, bus.o_driveNext);
        end
        chk("ovr_one_txn", 128'(cnt),           128'd1);
        chk("ovr_sticky",  128'(bus.o_overrun), 128'h1);

        // Reset while waiting on downstream.
        bus.i_data[2*DW +: DW] = 128'h55;
        cyc(4'b0100, 1'b0);
        cyc('0, 1'b0);
        chk("wait_busy", 128'(bus.o_busy), 128'h1);
        #1 rst = 1'b0;
        #1;
        chk("arst_free",    128'(bus.o_free),      128'h0);
        chk("arst_drv",     128'(bus.o_driveNext), 128'h0);
        chk("arst_data",    bus.o_data,            128'h0);
        chk("arst_grant",   128'(bus.o_grant),     128'h0);
        chk("arst_busy",    128'(bus.o_busy),      128'h0);
        chk("arst_overrun", 128'(bus.o_overrun),   128'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        cyc('0, 1'b1);
        chk("arst_nofree", 128'(bus.o_free), 128'h0);
        chk("arst_idle",   128'(bus.o_busy), 128'h0);
        bus.i_data[3*DW +: DW] = 128'hC3;
        cyc(4'b1000, 1'b0); serve('0, g0);
        chk("post_rst_grant", 128'(g0),   128'd3);
        chk("post_rst_data",  bus.o_data, 128'hC3);
        repeat (2) cyc('0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cmutex_merge_n_d_sync.md
# cmutex_merge_n_d_sync

Clocked N-input mutual-exclusion merge with data, successor to the two-input asynchronous merge. Collects single-cycle drive requests from N_IN upstream channels and arbitrates between them. Forwards one channel at a time to a single downstream drive/free handshake. Granted data is registered and held stable until the next grant, so the output data persists, unlike the combinational-mux predecessor.

## Interface
- DATA_WIDTH, 128: payload width per channel.
- N_IN, 4: number of input channels, at least 2.
- IDX_W, $clog2(N_IN): localparam, grant index width.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_drive  in  N_IN  per-channel request pulse, one cycle.
- o_free  out  N_IN  per-channel completion pulse, one cycle.
- i_data  in  N_IN*DATA_WIDTH  channel k occupies [k*DATA_WIDTH +: DATA_WIDTH]. Held by upstream from drive until its o_free.
- o_driveNext  out  1  downstream request pulse, one cycle.
- i_freeNext  in  1  downstream completion pulse.
- o_data  out  DATA_WIDTH  registered payload of the current or last grant.
- o_grant  out  IDX_W  index of the current or last granted channel.
- o_busy  out  1  high while in WAIT.
- o_overrun  out  1  sticky: a drive arrived on an already-pending channel.

## Operation
- pending[N_IN] register:
  - i_drive[k] sets pending[k].
  - Completion of channel k clears pending[k].
  - If set and clear coincide on the same k, set wins.
- o_overrun: i_drive[k] while pending[k]=1 and not clearing that cycle sets o_overrun. The drive is otherwise ignored. Only reset clears o_overrun.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - If pending is nonzero, select winner g and latch o_data <= i_data[g], o_grant <= g.
  - Pulse o_driveNext and go to WAIT.
  - i_freeNext in IDLE is ignored.
- WAIT:
  - On i_freeNext=1, pulse o_free[g], clear pending[g] and return to IDLE.
  - i_drive pulses are still recorded in pending.
- Arbitration: see Configuration. The round-robin pointer last is updated to g at each grant.
- o_data and o_grant hold their values after completion until the next grant.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Reset values: o_free=0, o_driveNext=0, o_data=0, o_grant=0, o_busy=0, o_overrun=0, pending=0, state=IDLE, last=N_IN-1.
- Sequence for an idle block. Cycle c0 is the cycle with i_drive[k] high.
  - Edge E1: pending[k] set.
  - Edge E2: grant. o_data, o_grant, o_driveNext=1 and o_busy=1 are all valid in cycle c2.
- i_freeNext is accepted only in WAIT. The earliest accepted i_freeNext is in c2, sampled at E3. o_free[g]=1 in c3, with o_busy=0.
- The next grant is no earlier than edge E4. Minimum period is 2 cycles per transaction with a back-to-back pending queue and immediate freeNext.
- o_driveNext and o_free are exactly one cycle wide.
- Reset asserted mid-transaction: everything clears immediately. No o_free is emitted for the aborted grant. Upstream must re-drive.
- Simultaneous drives on several channels are all recorded and served one per transaction in arbitration order.

## Configuration
- CMUTEXMERGE_RR_EN defined:
  - Round-robin arbitration. Search starts at (last+1) mod N_IN and wraps around.
  - After reset, channel 0 has highest priority.
- CMUTEXMERGE_RR_EN undefined:
  - Fixed priority, lowest index wins.
  - The last register and its logic are removed.
  - o_grant behaves identically otherwise.

## Test plan
- Single request, N_IN=4: i_drive[2] pulse in c0 with i_data[2]=0xA5 and i_freeNext returned in c2 -> o_driveNext in c2, o_data=0xA5, o_grant=2, o_free[2] in c3, o_busy low from c3.
- Simultaneous i_drive=4'b1011 with RR_EN and immediate freeNext -> grants 0,1,3 in that order, one o_free pulse each. Without RR_EN, a re-drive of channel 0 after each of its frees starves channels 1 and 3.
- Round-robin wrap: last=3, pending=4'b1001 -> grant 0. Then re-drive 3 -> grant 3. Then re-drive 0 -> grant 0.
- Overrun: second i_drive[1] while channel 1 is pending -> o_overrun=1 and stays high; exactly one transaction is served for channel 1.
- Persistence and the ignored-free rule: after completion, change i_data[g] -> o_data unchanged. Spurious i_freeNext in IDLE -> no o_free and no state change.
- Reset in WAIT with i_freeNext then pulsed -> all outputs 0, no o_free. The next request is served normally.
